// File: rtl/resistor_scan_pkg.sv
// rtl/resistor_scan_pkg.sv - shared types and helpers for the resistor scan sequencer
package resistor_scan_pkg;

    localparam int SCAN_MAX_CH   = 8;
    localparam int SCAN_MAX_CH_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        BREAK,
        SETTLE,
        MEASURE,
        REPORT
    } scan_state_t;

    typedef struct packed {
        logic [SCAN_MAX_CH_W-1:0] ch;
        logic [31:0]              count;
        logic                     timeout;
    } scan_result_t;

    // Lowest set bit of mask at or above index from; -1 when there is none.
    function automatic int next_set_bit(input logic [SCAN_MAX_CH-1:0] mask, input int from);
        next_set_bit = -1;
        for (int i = SCAN_MAX_CH - 1; i >= 0; i--) begin
            if (i >= from && mask[i]) begin
                next_set_bit = i;
            end
        end
    endfunction

endpackage

// File: rtl/resistor_scan_ctrl_if.sv
// rtl/resistor_scan_ctrl_if.sv - control, analog-switch and result-stream bundle of the scan sequencer
interface resistor_scan_ctrl_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 12
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic             start;
    logic             abort;
    logic             cont;
    logic [N_CH-1:0]  ch_mask;
    logic             cmp_in;
    logic [N_CH-1:0]  sw_en;
    logic             discharge_o;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [CH_W-1:0]  res_ch;
    logic [CNT_W-1:0] res_count;
    logic             res_timeout;

    modport master (
        input  start, abort, cont, ch_mask, cmp_in, res_ready,
        output sw_en, discharge_o, busy, res_valid, res_ch, res_count, res_timeout
    );

    modport slave (
        output start, abort, cont, ch_mask, cmp_in, res_ready,
        input  sw_en, discharge_o, busy, res_valid, res_ch, res_count, res_timeout
    );
endinterface

// File: rtl/resistor_scan_ctrl_sync2.sv
// rtl/resistor_scan_ctrl_sync2.sv - two-flop synchroniser for the asynchronous comparator input
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/resistor_scan_ctrl.sv
// rtl/resistor_scan_ctrl.sv - resistor channel scan sequencer; RSCAN_AVG4_EN enables 4-pass averaging
module resistor_scan_ctrl
    import resistor_scan_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 12,
    parameter int SETTLE_CYC = 16,
    parameter int BBM_CYC    = 2,
    parameter int MAX_COUNT  = 4095
) (
    input  logic                  clk,
    input  logic                  rst,
    resistor_scan_ctrl_if.master  bus
);
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TMR_MAX = (SETTLE_CYC > BBM_CYC) ? SETTLE_CYC : BBM_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    scan_state_t      state_q, state_d;
    logic [N_CH-1:0]  mask_q;
    logic [CH_W-1:0]  ch_q;
    logic [TMR_W-1:0] tmr_q;
    logic [CNT_W-1:0] meas_q;
    logic [CH_W-1:0]  res_ch_q;
    logic [CNT_W-1:0] res_count_q;
    logic             res_timeout_q;

    logic cmp_s;
    logic start_ok;
    logic bbm_done;
    logic settle_done;
    logic meas_to;
    logic meas_end;
    logic last_pass;
    logic more_hi;

    sync2 u_cmp_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.cmp_in),
        .q   (cmp_s)
    );

    assign start_ok    = bus.start && (bus.ch_mask != '0);
    assign bbm_done    = tmr_q == TMR_W'(BBM_CYC - 1);
    assign settle_done = tmr_q == TMR_W'(SETTLE_CYC - 1);
    assign meas_to     = meas_q == CNT_W'(MAX_COUNT);
    // The comparator takes priority over the timeout when both land on the same cycle.
    assign meas_end    = cmp_s || meas_to;
    assign more_hi     = next_set_bit(8'(mask_q), int'(ch_q) + 1) >= 0;

`ifdef RSCAN_AVG4_EN
    logic [1:0]       pass_q;
    logic [CNT_W+1:0] acc_q;
    logic [CNT_W+1:0] acc_sum;
    logic             tout_q;

    assign last_pass = pass_q == 2'd3;
    assign acc_sum   = acc_q + (CNT_W + 2)'(meas_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_q <= '0;
            acc_q  <= '0;
            tout_q <= 1'b0;
        end else if (bus.abort || (state_q == IDLE) || (state_q == MEASURE && meas_end && last_pass)) begin
            pass_q <= '0;
            acc_q  <= '0;
            tout_q <= 1'b0;
        end else if (state_q == MEASURE && meas_end) begin
            pass_q <= pass_q + 2'd1;
            acc_q  <= acc_sum;
            tout_q <= tout_q | !cmp_s;
        end
    end
`else
    assign last_pass = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_ok)    state_d = BREAK;
                BREAK:   if (bbm_done)    state_d = SETTLE;
                SETTLE:  if (settle_done) state_d = MEASURE;
                MEASURE: if (meas_end)    state_d = last_pass ? REPORT : BREAK;
                REPORT:  if (bus.res_ready) state_d = (more_hi || bus.cont) ? BREAK : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.sw_en       = '0;
        bus.discharge_o = 1'b1;
        bus.busy        = state_q != IDLE;
        bus.res_valid   = 1'b0;
        case (state_q)
            SETTLE:  bus.sw_en = N_CH'(1) << ch_q;
            MEASURE: begin
                bus.sw_en       = N_CH'(1) << ch_q;
                bus.discharge_o = 1'b0;
            end
            REPORT:  bus.res_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.res_ch      = res_ch_q;
    assign bus.res_count   = res_count_q;
    assign bus.res_timeout = res_timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || bus.abort) begin
            mask_q        <= '0;
            ch_q          <= '0;
            tmr_q         <= '0;
            meas_q        <= '0;
            res_ch_q      <= '0;
            res_count_q   <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_ok) begin
                    mask_q <= bus.ch_mask;
                    ch_q   <= CH_W'(next_set_bit(8'(bus.ch_mask), 0));
                    tmr_q  <= '0;
                end
                BREAK:  tmr_q <= bbm_done ? '0 : tmr_q + 1'b1;
                SETTLE: begin
                    tmr_q  <= settle_done ? '0 : tmr_q + 1'b1;
                    meas_q <= '0;
                end
                MEASURE: if (meas_end) begin
                    res_ch_q <= ch_q;
`ifdef RSCAN_AVG4_EN
                    if (last_pass) begin
                        res_count_q   <= CNT_W'(acc_sum >> 2);
                        res_timeout_q <= tout_q | !cmp_s;
                    end
`else
                    res_count_q   <= meas_q;
                    res_timeout_q <= !cmp_s;
`endif
                end else begin
                    meas_q <= meas_q + 1'b1;
                end
                REPORT: if (bus.res_ready) begin
                    if (more_hi) begin
                        ch_q <= CH_W'(next_set_bit(8'(mask_q), int'(ch_q) + 1));
                    end else if (bus.cont) begin
                        ch_q <= CH_W'(next_set_bit(8'(mask_q), 0));
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
